// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared CPU constants for the register file and the issue scoreboard
package reg_scoreboard_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREG = 32;
  localparam int SB_NREG = RF_NREG;
  localparam int SB_PEND_W = 2;
  typedef logic [RF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: per-register pending-write counter; saturates at all-ones, never goes below zero
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int W = SB_PEND_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         err
);
  localparam logic [W-1:0] MAX = '1;
  assign err = dec && count == '0;
  // simultaneous inc and dec cancel; clear and reset dominate
  always_ff @(posedge CLK)
    if (!RST_N || clr) count <= '0;
    else if (inc && !dec && count != MAX) count <= count + 1'b1;
    else if (dec && !inc && count != '0) count <= count - 1'b1;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks outstanding register writes and stalls issue on RAW hazards or full counters
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int PEND_W = SB_PEND_W,
  parameter int NREG = SB_NREG
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            ISSUE_VALID,
  input  reg_idx_t        ISSUE_RD,
  input  reg_idx_t        ISSUE_RS1,
  input  reg_idx_t        ISSUE_RS2,
  input  logic            ISSUE_USE1,
  input  logic            ISSUE_USE2,
  input  logic            WB_VALID,
  input  reg_idx_t        WB_RD,
  input  logic            FLUSH,
  output logic            STALL,
  output logic [NREG-1:0] BUSY_VEC,
  output logic            PENDING_ANY,
  output logic            WB_ERR
);
  logic [PEND_W-1:0] cnt [NREG];
  logic [NREG-1:0] err_v;
  logic haz1, haz2, full, accept;
  localparam logic [PEND_W-1:0] ONE = PEND_W'(1);
  // a source whose only pending write retires this cycle is readable: the register file writes before it reads
  assign haz1 = ISSUE_USE1 && ISSUE_RS1 != '0 && cnt[ISSUE_RS1] != '0 &&
                !(cnt[ISSUE_RS1] == ONE && WB_VALID && WB_RD == ISSUE_RS1);
  assign haz2 = ISSUE_USE2 && ISSUE_RS2 != '0 && cnt[ISSUE_RS2] != '0 &&
                !(cnt[ISSUE_RS2] == ONE && WB_VALID && WB_RD == ISSUE_RS2);
  assign full = ISSUE_RD != '0 && cnt[ISSUE_RD] == '1;
  assign STALL = ISSUE_VALID && (haz1 || haz2 || full);
  assign accept = ISSUE_VALID && !STALL && !FLUSH;
  assign cnt[0] = '0;
  assign err_v[0] = 1'b0;
  assign BUSY_VEC[0] = 1'b0;
  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    sb_counter #(.W(PEND_W)) u_cnt (
      .CLK   (CLK),
      .RST_N (RST_N),
      .inc   (accept && ISSUE_RD == reg_idx_t'(i)),
      .dec   (WB_VALID && WB_RD == reg_idx_t'(i)),
      .clr   (FLUSH),
      .count (cnt[i]),
      .err   (err_v[i])
    );
    assign BUSY_VEC[i] = |cnt[i];
  end
  assign PENDING_ANY = |BUSY_VEC;
  // sticky underflow flag; only reset clears it, flush leaves it alone
  always_ff @(posedge CLK)
    if (!RST_N) WB_ERR <= 1'b0;
    else if (|err_v) WB_ERR <= 1'b1;
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter PEND_W, default 2, giving the per-register pending-count width, so the maximum is 2^PEND_W-1 = 3.
REQ-002 The block SHALL have parameter NREG, default 32, giving the number of architectural registers tracked.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST_N  input  1  reset; synchronous, active-low.
REQ-005 ISSUE_VALID  input  1  decode stage presents an instruction.
REQ-006 ISSUE_RD  input  5  destination register of the issuing instruction; 0 means no write.
REQ-007 ISSUE_RS1, ISSUE_RS2  input  5 each  source registers.
REQ-008 ISSUE_USE1, ISSUE_USE2  input  1 each  source 1 / source 2 actually read.
REQ-009 WB_VALID  input  1  writeback stage retires a write this cycle; mirrors the register-file RegWrite.
REQ-010 WB_RD  input  5  writeback destination; mirrors the register-file A3.
REQ-011 FLUSH  input  1  pipeline flush; discards all outstanding writes.
REQ-012 STALL  output  1  combinational; issue must hold this cycle.
REQ-013 BUSY_VEC  output  NREG  registered; bit i = pending count of register i is nonzero.
REQ-014 PENDING_ANY  output  1  OR of BUSY_VEC.
REQ-015 WB_ERR  output  1  sticky; writeback seen for a register with count 0.

Function
REQ-016 The block SHALL hold one PEND_W-bit pending counter per register; the register-0 counter SHALL be constant 0.
REQ-017 A source SHALL be hazardous when its USE bit is 1, its index is nonzero, and its count is nonzero.
- Exception: count == 1 AND WB_VALID AND WB_RD equals that index is not hazardous. The register file writes in the first half-cycle and reads in the second.
REQ-018 STALL SHALL equal ISSUE_VALID AND (rs1 hazardous OR rs2 hazardous OR (ISSUE_RD != 0 AND count[ISSUE_RD] == 3)).
REQ-019 Issue is accepted when ISSUE_VALID AND NOT STALL AND NOT FLUSH.
- On acceptance with ISSUE_RD != 0, count[ISSUE_RD] SHALL increment at the next edge.
REQ-020 A writeback with WB_VALID AND WB_RD != 0 AND count[WB_RD] != 0 SHALL decrement count[WB_RD] at the next edge.
REQ-021 An accepted issue and a writeback to the same register in the same cycle SHALL leave its count unchanged.
- This also applies at count 3: the writeback frees the slot only after the edge, so STALL is still asserted by REQ-018 and no issue is accepted.
REQ-022 A writeback with WB_RD != 0 and count[WB_RD] == 0 SHALL set WB_ERR and leave the count at 0; counts SHALL never wrap.
REQ-023 FLUSH SHALL clear all counters at the next edge, overriding issue and writeback that cycle.
- WB_ERR SHALL be unaffected by FLUSH.
REQ-024 Writebacks to register 0 SHALL be ignored and SHALL never set WB_ERR.
REQ-025 The block SHALL have zero-cycle latency from inputs to STALL and one-cycle latency from an accepted event to BUSY_VEC and PENDING_ANY.

Reset
REQ-026 While RST_N == 0 at a posedge, all counters, BUSY_VEC, PENDING_ANY and WB_ERR SHALL become 0.
- This includes reset asserted mid-operation with writes outstanding.
REQ-027 STALL SHALL evaluate to 0 after reset until an issue is accepted.
- Reset SHALL take priority over FLUSH, issue and writeback.

Structure
REQ-028 NREG, PEND_W and the register-index width (5) SHALL live in the shared CPU package, alongside the register-file constants.
REQ-029 The per-register counter SHALL be one sub-module, sb_counter, instantiated NREG-1 times.
- Ports: inc, dec, clr, count, err.
- Saturation and underflow behaviour SHALL be confined to sb_counter.
REQ-030 The block SHALL contain no latches, and the only combinational path SHALL be issue/writeback inputs to STALL.

Verification
REQ-031 Basic hazard:
- Reset, then issue RD=5.
- Next cycle, issue USE1=1 RS1=5 -> STALL=1, BUSY_VEC[5]=1.
- WB_VALID WB_RD=5 that cycle -> STALL=0 same cycle; BUSY_VEC[5]=0 next cycle.
REQ-032 Saturation:
- Issue RD=7 three times -> count 3.
- Fourth issue RD=7 -> STALL=1.
- WB RD=7 -> count 2 next cycle; fourth issue then accepted.
REQ-033 Simultaneous events:
- count[9]=1, issue RD=9 with WB RD=9 same cycle -> count[9] stays 1, BUSY_VEC[9]=1.
REQ-034 Underflow:
- WB_VALID WB_RD=12 with count 0 -> WB_ERR=1 held, count 0.
- WB RD=0 -> no WB_ERR.
REQ-035 Flush:
- Registers 3, 4 and 31 pending, FLUSH=1 with issue RD=3 -> all counts 0 next cycle, PENDING_ANY=0.
REQ-036 Reset mid-operation:
- Counts nonzero, WB_ERR=1, RST_N=0 one edge -> all outputs 0.
- Issue USE1=1 RS1=3 -> STALL=0.
